// File: rtl/ram_burst_reader.sv
// Burst read master for the dual-port RAM: walks base..base+len-1 with wrap and streams words out.
// Optional BURST_RD_ABORT_EN adds an abort input that cancels a running burst.
module ram_burst_reader #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [AW-1:0]    base_addr,
  input  logic [AW:0]      len,
`ifdef BURST_RD_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic             renc,
  output logic [AW-1:0]    raddr,
  input  logic [WIDTH-1:0] rdata,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  localparam logic [AW:0]   ONE      = 1;
  localparam logic [AW-1:0] LAST_ADR = AW'(DEPTH - 1);

  state_t           state;
  logic [AW:0]      len_q;
  logic [AW:0]      issued;
  logic [AW:0]      popped;
  logic [AW-1:0]    addr_q;
  logic             inflight;
  logic [WIDTH-1:0] buf_mem [3];
  logic [1:0]       head;
  logic [1:0]       tail;
  logic [1:0]       occ;
  logic             push;
  logic             pop;
  logic             abort_hit;

`ifdef BURST_RD_ABORT_EN
  assign abort_hit = abort && busy;
`else
  assign abort_hit = 1'b0;
`endif

  // Credit check counts the word still in the RAM pipeline so the 3-entry buffer never overflows.
  assign renc       = (state == READ) && (issued < len_q) &&
                      (({1'b0, occ} + {2'b00, inflight}) < 3'd3);
  assign raddr      = addr_q;
  assign dout       = buf_mem[head];
  assign dout_valid = (occ != 2'd0);
  assign push       = inflight;
  assign pop        = dout_valid && dout_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      len_q    <= '0;
      issued   <= '0;
      popped   <= '0;
      addr_q   <= '0;
      inflight <= 1'b0;
      head     <= 2'd0;
      tail     <= 2'd0;
      occ      <= 2'd0;
      for (int i = 0; i < 3; i++) buf_mem[i] <= '0;
    end else begin
      done <= 1'b0;
      if (abort_hit) begin
        state    <= IDLE;
        busy     <= 1'b0;
        done     <= 1'b1;
        inflight <= 1'b0;
        head     <= 2'd0;
        tail     <= 2'd0;
        occ      <= 2'd0;
      end else begin
        inflight <= renc;
        if (renc) begin
          issued <= issued + ONE;
          addr_q <= (addr_q == LAST_ADR) ? '0 : addr_q + 1'b1;
        end
        if (push) begin
          buf_mem[tail] <= rdata;
          tail          <= (tail == 2'd2) ? 2'd0 : tail + 2'd1;
        end
        if (pop) begin
          head   <= (head == 2'd2) ? 2'd0 : head + 2'd1;
          popped <= popped + ONE;
        end
        case ({push, pop})
          2'b10:   occ <= occ + 2'd1;
          2'b01:   occ <= occ - 2'd1;
          default: occ <= occ;
        endcase

        case (state)
          IDLE: begin
            if (start) begin
              if (len != '0) begin
                state  <= READ;
                busy   <= 1'b1;
                len_q  <= len;
                addr_q <= base_addr;
                issued <= '0;
                popped <= '0;
              end else begin
                done <= 1'b1;
              end
            end
          end
          READ: begin
            if (renc && (issued + ONE == len_q)) state <= DRAIN;
          end
          DRAIN: begin
            if (pop && (popped + ONE == len_q)) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ram_burst_reader.sv
// Bench for ram_burst_reader: table-driven bursts, random bursts against a queue model, reset/abort sequences.
module tb_ram_burst_reader;

  localparam int DEPTH = 16;
  localparam int WIDTH = 8;
  localparam int AW    = 4;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [AW-1:0]    base_addr;
  logic [AW:0]      len;
  logic             abort;
  logic             busy;
  logic             done;
  logic             renc;
  logic [AW-1:0]    raddr;
  logic [WIDTH-1:0] rdata;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;

  logic [WIDTH-1:0] mem [DEPTH];

  ram_burst_reader #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .len        (len),
`ifdef BURST_RD_ABORT_EN
    .abort      (abort),
`endif
    .busy       (busy),
    .done       (done),
    .renc       (renc),
    .raddr      (raddr),
    .rdata      (rdata),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (renc) rdata <= mem[raddr];

  int tests = 0;
  int failed = 0;
  int cyc = 0;
  int issues, pops, hs_cnt, done_cnt, done_cyc, last_hs_cyc, first_valid_cyc;
  int first_dout, last_dout;
  logic prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_dout = '0;
  int exp_q[$];
  int exp_addr[$];

  typedef struct {
    int b;
    int n;
    int mode;
    int exp_first;
    int exp_last;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic mon();
    if (renc) begin
      chk("credit", int'((issues - pops) < 3), 1);
      chk("renc_pending", int'(exp_addr.size() > 0), 1);
      if (exp_addr.size() > 0) chk("raddr", raddr, exp_addr.pop_front());
      issues++;
    end
    if (prev_stall) begin
      chk("stall_valid", dout_valid, 1);
      chk("stall_data", dout, prev_dout);
    end
    if (dout_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (dout_valid && dout_ready) begin
      chk("dout_pending", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) chk("dout", dout, exp_q.pop_front());
      if (hs_cnt == 0) first_dout = dout;
      last_dout = dout;
      hs_cnt++;
      pops++;
      last_hs_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    prev_stall = dout_valid && !dout_ready && !abort;
    prev_dout  = dout;
  endtask

  task automatic tick();
    @(negedge clk);
    if (rst_n) mon();
    else prev_stall = 1'b0;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  function automatic logic ready_for(input int mode, input int i);
    if (mode == 0) return 1'b1;
    if (mode == 1) return ($urandom % 3) != 0;
    case (i)
      0, 3:          return 1'b1;
      1, 2:          return 1'b0;
      4, 5, 6, 7, 8: return 1'b0;
      default:       return (i % 3) != 0;
    endcase
  endfunction

  task automatic clear_model();
    exp_q.delete();
    exp_addr.delete();
    issues = 0; pops = 0; hs_cnt = 0; done_cnt = 0; done_cyc = -1;
    last_hs_cyc = -1; first_valid_cyc = -1; first_dout = -1; last_dout = -1;
  endtask

  task automatic issue_start(input int b, input int n);
    clear_model();
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(int'(mem[(b + i) % DEPTH]));
      exp_addr.push_back((b + i) % DEPTH);
    end
    start     = 1'b1;
    base_addr = AW'(b);
    len       = (AW+1)'(n);
  endtask

  task automatic run_burst(input int b, input int n, input int mode, input bit spurious);
    int st;
    dout_ready = ready_for(mode, 0);
    issue_start(b, n);
    st = cyc;
    tick();
    start = 1'b0;
    chk("busy_start", busy, int'(n != 0));
    for (int i = 0; i < 300 && done_cnt == 0; i++) begin
      dout_ready = ready_for(mode, i);
      if (spurious) begin
        start     = busy && (($urandom % 4) == 0);
        base_addr = AW'($urandom);
        len       = (AW+1)'($urandom_range(0, DEPTH));
      end
      tick();
    end
    start = 1'b0;
    dout_ready = 1'b1;
    chk("done_seen", done_cnt, 1);
    tick();
    tick();
    chk("done_pulse_once", done_cnt, 1);
    chk("busy_after", busy, 0);
    chk("words", hs_cnt, n);
    chk("addr_left", exp_addr.size(), 0);
    if (n > 0) chk("done_timing", done_cyc, last_hs_cyc + 1);
    else       chk("done_timing", done_cyc, st + 1);
    if (mode == 0 && n > 0) begin
      chk("first_latency", first_valid_cyc - st, 3);
      chk("throughput", last_hs_cyc - first_valid_cyc, n - 1);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_renc"}, renc, 0);
    chk({tag, "_raddr"}, raddr, 0);
    chk({tag, "_dout_valid"}, dout_valid, 0);
    chk({tag, "_dout"}, dout, 0);
  endtask

  vec_t vecs [6];

  initial begin
    vecs[0] = '{b: 2,  n: 4,  mode: 0, exp_first: 'h12, exp_last: 'h15};
    vecs[1] = '{b: 14, n: 4,  mode: 0, exp_first: 'h1E, exp_last: 'h11};
    vecs[2] = '{b: 0,  n: 8,  mode: 2, exp_first: 'h10, exp_last: 'h17};
    vecs[3] = '{b: 3,  n: 0,  mode: 0, exp_first: -1,   exp_last: -1};
    vecs[4] = '{b: 5,  n: 16, mode: 0, exp_first: 'h15, exp_last: 'h14};
    vecs[5] = '{b: 15, n: 1,  mode: 2, exp_first: 'h1F, exp_last: 'h1F};

    for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'(8'h10 + i);
    rst_n = 1'b0; start = 1'b0; base_addr = '0; len = '0; abort = 1'b0; dout_ready = 1'b1;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    rst_n = 1'b1;
    tick();

    foreach (vecs[k]) begin
      run_burst(vecs[k].b, vecs[k].n, vecs[k].mode, 1'b0);
      if (vecs[k].n > 0) begin
        chk("first_word", first_dout, vecs[k].exp_first);
        chk("last_word", last_dout, vecs[k].exp_last);
      end
    end

    for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'($urandom);
    for (int r = 0; r < 25; r++) run_burst($urandom % DEPTH, $urandom_range(0, DEPTH), 1, 1'b1);
    for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'(8'h10 + i);

    // Reset in the middle of a burst after two words have left.
    dout_ready = 1'b1;
    issue_start(2, 8);
    tick();
    start = 1'b0;
    for (int i = 0; i < 50 && hs_cnt < 2; i++) tick();
    chk("rst_wait", hs_cnt, 2);
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("midrst");
    clear_model();
    tick();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("no_done_after_reset", done_cnt, 0);
    run_burst(0, 2, 0, 1'b0);
    chk("post_rst_first", first_dout, 'h10);
    chk("post_rst_last", last_dout, 'h11);

`ifdef BURST_RD_ABORT_EN
    dout_ready = 1'b0;
    issue_start(0, 8);
    tick();
    start = 1'b0;
    repeat (6) tick();
    chk("abort_pre_valid", dout_valid, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_valid", dout_valid, 0);
    chk("abort_renc", renc, 0);
    chk("abort_done", done, 1);
    chk("abort_busy", busy, 0);
    clear_model();
    tick();
    chk("abort_done_pulse", done, 0);
    run_burst(4, 3, 0, 1'b0);
    chk("post_abort_first", first_dout, 'h14);
    chk("post_abort_last", last_dout, 'h16);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
